dbg_frame_tx: RTL
=================

// Module: dbg_frame_tx
// PURPOSE
//  Debug-frame serializer between the processor core and the UART transmitter.
//  On a halt pulse from the control block it snapshots PC, accumulator and cycles-run-since-last-frame,
//  then streams them as a fixed byte frame over a valid/ready byte interface into the UART TX.
//  Runs in parallel with the core; never stalls the datapath.
// PARAMETERS
//  AB      11     program address width; must satisfy 1 <= AB <= 16; PC is zero-extended to 16 bits
//  DB      16     accumulator width; must satisfy 1 <= DB <= 16; ACC is zero-extended to 16 bits
//  HDR     8'hA5  frame header byte
// PORTS
//  clk         in   1     system clock, rising edge
//  reset       in   1     asynchronous, active-low reset
//  cpu_run     in   1     core enabled this cycle; cycle counter advances
//  halt        in   1     one-cycle pulse: core executed halt, snapshot request
//  pc          in   AB    current program counter
//  acc         in   DB    current accumulator value
//  tx_data     out  8     frame byte offered to UART TX
//  tx_valid    out  1     tx_data valid; held with stable data until accepted
//  tx_ready    in   1     UART TX can accept a byte; transfer when tx_valid & tx_ready
//  busy        out  1     frame capture/transmission in progress (state != IDLE)
//  frame_done  out  1     one-cycle pulse after last byte accepted
//  overrun     out  1     sticky: halt arrived while busy; cleared only by reset
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, tx_valid=0, tx_data=0, busy=0, frame_done=0, overrun=0,
//    byte index=0, cycle counter=0, snapshot regs=0. Takes effect immediately, including mid-frame.
//  - Cycle counter: 16 bit, +1 each clk with cpu_run=1, saturates at 16'hFFFF (no wrap).
//  - States: IDLE -> SEND -> DONE -> IDLE.
//  - IDLE: on halt=1, register {pc,acc,counter} (counter value before this edge's increment),
//    clear counter to 0 at the same edge, idx=0, go SEND. The halt cycle itself is not counted.
//  - SEND: tx_valid=1, tx_data=byte[idx]; first byte valid on the cycle after halt (latency 1).
//    On tx_valid&tx_ready: idx+1; when idx==LAST -> DONE. Data/idx unchanged while tx_ready=0.
//  - DONE: tx_valid=0, frame_done=1 for exactly one cycle, then IDLE; halt in DONE counts as overrun.
//  - Frame bytes: 0 HDR, 1 PC[15:8], 2 PC[7:0], 3 ACC[15:8], 4 ACC[7:0], 5 CYC[15:8], 6 CYC[7:0].
//  - halt while busy (SEND/DONE): ignored, snapshot untouched, overrun<=1. Counter keeps counting.
//  - halt with cpu_run=1 same cycle: snapshot excludes that cycle; counter restarts at 0.
//  - No output depends combinationally on tx_ready (all outputs registered).
// CONFIGURATION
//  DBG_CHECKSUM_EN defined: frame is 8 bytes, byte 7 = XOR of bytes 1..6; LAST=7.
//  Not defined: frame is 7 bytes, LAST=6, no checksum logic present.
// STRUCTURE
//  Package dbg_frame_pkg: state encoding (IDLE/SEND/DONE), HDR default, FRAME_LEN and LAST constants
//  for both macro settings, byte-index width.
//  One sub-module: dbg_cycle_counter (16 bit saturating counter, en + sync clear, async active-low reset).
//  Byte mux, FSM and checksum accumulator stay in dbg_frame_tx.
// TESTING
//  1 Assert reset=0 -> all outputs 0, busy=0; release -> stays IDLE, tx_valid=0.
//  2 cpu_run=1 for 10 cycles, then halt with cpu_run=0, pc=11'h123, acc=16'hBEEF, tx_ready=1 ->
//    bytes A5 01 23 BE EF 00 0A on consecutive cycles, frame_done pulse next cycle, overrun=0.
//    With DBG_CHECKSUM_EN: extra byte 8'h79.
//  3 Same as 2 with tx_ready high one cycle in three -> identical byte sequence, tx_data stable while
//    tx_valid=1 & tx_ready=0, no byte dropped or duplicated.
//  4 Second halt during SEND -> overrun=1, current frame unchanged; next halt after frame_done sends
//    new frame whose CYC counts cycles since the first halt.
//  5 cpu_run=1 for 70000 cycles then halt -> CYC bytes FF FF.
//  6 reset=0 during byte 3 of a frame -> tx_valid=0 immediately, busy=0; new halt gives clean frame
//    starting at A5 with CYC counted from reset release.

Source files
------------

// File: rtl/dbg_frame_pkg.sv
// Shared constants and state encoding for the debug frame serializer.
// DBG_CHECKSUM_EN appends an XOR checksum byte to every frame.
package dbg_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;
  localparam int IDX_W = 3;

  localparam int FRAME_LEN_CK = 8;
  localparam int LAST_CK      = 7;
  localparam int FRAME_LEN_NC = 7;
  localparam int LAST_NC      = 6;

`ifdef DBG_CHECKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_CK;
  localparam int LAST      = LAST_CK;
`else
  localparam int FRAME_LEN = FRAME_LEN_NC;
  localparam int LAST      = LAST_NC;
`endif

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST);

endpackage

// File: rtl/dbg_cycle_counter.sv
// 16-bit saturating cycle counter with enable and synchronous clear.
// Clear wins over enable so a snapshot edge always restarts at zero.
module dbg_cycle_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  output logic [15:0] cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= 16'h0000;
    end else if (clr) begin
      cnt <= 16'h0000;
    end else if (en && cnt != 16'hFFFF) begin
      cnt <= cnt + 16'h0001;
    end
  end

endmodule

// File: rtl/dbg_frame_tx.sv
// Debug frame serializer: snapshots PC/ACC/cycles on halt, streams bytes.
// DBG_CHECKSUM_EN adds a trailing XOR checksum over bytes 1..6.
module dbg_frame_tx
  import dbg_frame_pkg::*;
#(
  parameter int          AB  = 11,
  parameter int          DB  = 16,
  parameter logic [7:0]  HDR = HDR_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_run,
  input  logic          halt,
  input  logic [AB-1:0] pc,
  input  logic [DB-1:0] acc,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          busy,
  output logic          frame_done,
  output logic          overrun
);

  state_e           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] nxt_idx;
  logic [15:0]      snap_pc;
  logic [15:0]      snap_acc;
  logic [15:0]      snap_cyc;
  logic [15:0]      cyc;
  logic [7:0]       next_byte;
  logic             take;
  logic             capture;

  assign capture = halt && (state == IDLE);
  assign take    = (state == SEND) && tx_valid && tx_ready;
  assign nxt_idx = idx + IDX_W'(1);
  assign busy    = (state != IDLE);

  dbg_cycle_counter u_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (cpu_run),
    .clr   (capture),
    .cnt   (cyc)
  );

`ifdef DBG_CHECKSUM_EN
  logic [7:0] csum;

  // Running XOR of accepted payload bytes; header resets it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum <= 8'h00;
    end else if (take) begin
      csum <= (idx == '0) ? 8'h00 : (csum ^ tx_data);
    end
  end
`endif

  always_comb begin
    next_byte = 8'h00;
    case (nxt_idx)
      3'd1:    next_byte = snap_pc[15:8];
      3'd2:    next_byte = snap_pc[7:0];
      3'd3:    next_byte = snap_acc[15:8];
      3'd4:    next_byte = snap_acc[7:0];
      3'd5:    next_byte = snap_cyc[15:8];
      3'd6:    next_byte = snap_cyc[7:0];
`ifdef DBG_CHECKSUM_EN
      3'd7:    next_byte = csum ^ tx_data;
`endif
      default: next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      snap_pc    <= 16'h0000;
      snap_acc   <= 16'h0000;
      snap_cyc   <= 16'h0000;
    end else begin
      frame_done <= 1'b0;
      if (halt && state != IDLE) begin
        overrun <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (halt) begin
            snap_pc  <= 16'(pc);
            snap_acc <= 16'(acc);
            snap_cyc <= cyc;
            idx      <= '0;
            tx_data  <= HDR;
            tx_valid <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (idx == LAST_IDX) begin
              idx        <= '0;
              tx_valid   <= 1'b0;
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              idx     <= nxt_idx;
              tx_data <= next_byte;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
